// File: rtl/repeat_counter_pkg.sv
// Shared definitions for the button repeat counter: repeat FSM encodings,
// default timing and a small helper for sizing the repeat timer.
package repeat_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_HOLD_CYCLES   = 25_000_000;
    localparam int DEF_REPEAT_CYCLES = 5_000_000;
    localparam int DEF_WRAP          = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/repeat_counter_repeat_gen.sv
// Per-button repeat generator: one registered step on press, then a step
// after HOLD_CYCLES of hold and every REPEAT_CYCLES while still held.
//
//   state     | meaning
//   ST_IDLE   | waiting for a press pulse
//   ST_HOLD   | press step issued, timing the initial hold delay
//   ST_REPEAT | auto-repeating at the repeat rate while held
module repeat_gen
    import repeat_counter_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic press_pulse,
    input  logic press_level,
    output logic step
);

    localparam int TIMER_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

    rep_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               step_q, step_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_pulse) begin
                    step_d  = 1'b1;
                    timer_d = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!press_level) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (timer_q == HOLD_LAST) begin
                    step_d  = 1'b1;
                    timer_d = '0;
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!press_level) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (timer_q == REPEAT_LAST) begin
                    step_d  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign step = step_q;

endmodule

// File: rtl/repeat_counter.sv
// Up/down LED counter driven by debounced INC/DEC buttons with press-and-hold
// auto-repeat; coincident INC and DEC steps cancel.
module repeat_counter
    import repeat_counter_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int WRAP          = DEF_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_down,
    input  logic             inc_state,
    input  logic             dec_down,
    input  logic             dec_state,
    output logic [WIDTH-1:0] count,
    output logic             count_changed
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             inc_step;
    logic             dec_step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             changed_q, changed_d;

    repeat_gen #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_inc_rep (
        .clk         (clk),
        .rst         (rst),
        .press_pulse (inc_down),
        .press_level (inc_state),
        .step        (inc_step)
    );

    repeat_gen #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_dec_rep (
        .clk         (clk),
        .rst         (rst),
        .press_pulse (dec_down),
        .press_level (dec_state),
        .step        (dec_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            changed_q <= changed_d;
        end
    end

    // Saturating mode suppresses the step, and its pulse, at the rails.
    always_comb begin
        count_d   = count_q;
        changed_d = 1'b0;
        if (inc_step && !dec_step) begin
            if ((WRAP != 0) || (count_q != CNT_MAX)) begin
                count_d   = count_q + 1'b1;
                changed_d = 1'b1;
            end
        end else if (dec_step && !inc_step) begin
            if ((WRAP != 0) || (count_q != '0)) begin
                count_d   = count_q - 1'b1;
                changed_d = 1'b1;
            end
        end
    end

    assign count         = count_q;
    assign count_changed = changed_q;

endmodule

// File: tb/tb_repeat_counter.sv
// Directed bench for repeat_counter: a wrapping and a saturating instance
// share the same button stimulus, each checked against hand-computed values.
module tb_repeat_counter;
    import repeat_counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       inc_down, inc_state, dec_down, dec_state;
    logic [3:0] count_w, count_s;
    logic       changed_w, changed_s;

    int errors = 0;
    int checks = 0;
    int pulses_w = 0;
    int pulses_s = 0;

    repeat_counter #(.WIDTH(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst),
        .inc_down(inc_down), .inc_state(inc_state),
        .dec_down(dec_down), .dec_state(dec_state),
        .count(count_w), .count_changed(changed_w)
    );

    repeat_counter #(.WIDTH(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst),
        .inc_down(inc_down), .inc_state(inc_state),
        .dec_down(dec_down), .dec_state(dec_state),
        .count(count_s), .count_changed(changed_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (changed_w === 1'b1) pulses_w++;
        if (changed_s === 1'b1) pulses_s++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        inc_down  = 1'b0;
        inc_state = 1'b0;
        dec_down  = 1'b0;
        dec_state = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        pulses_w = 0;
        pulses_s = 0;
    endtask

    task automatic tap(input bit do_inc, input bit do_dec, output logic chw, output logic chs);
        inc_down  = do_inc;
        inc_state = do_inc;
        dec_down  = do_dec;
        dec_state = do_dec;
        tick();
        inc_down = 1'b0;
        dec_down = 1'b0;
        tick();
        chw = changed_w;
        chs = changed_s;
        inc_state = 1'b0;
        dec_state = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (count_w !== 4'd0) begin errors++; $display("FAIL reset_count_w: got %0d expected 0", count_w); end
        checks++; if (changed_w !== 1'b0) begin errors++; $display("FAIL reset_changed_w: got %0b expected 0", changed_w); end
        checks++; if (count_s !== 4'd0) begin errors++; $display("FAIL reset_count_s: got %0d expected 0", count_s); end
        checks++; if (dut_w.u_inc_rep.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_inc_state: got %0d expected %0d", dut_w.u_inc_rep.state_q, ST_IDLE); end
        checks++; if (dut_w.u_dec_rep.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_dec_state: got %0d expected %0d", dut_w.u_dec_rep.state_q, ST_IDLE); end
        checks++; if (dut_w.u_inc_rep.step_q !== 1'b0) begin errors++; $display("FAIL reset_inc_step: got %0b expected 0", dut_w.u_inc_rep.step_q); end
    endtask

    task automatic test_single_tap();
        apply_reset();
        inc_down  = 1'b1;
        inc_state = 1'b1;
        tick();
        inc_down = 1'b0;
        checks++; if (count_w !== 4'd0) begin errors++; $display("FAIL tap_latency1: got %0d expected 0", count_w); end
        tick();
        checks++; if (count_w !== 4'd1) begin errors++; $display("FAIL tap_count: got %0d expected 1", count_w); end
        checks++; if (changed_w !== 1'b1) begin errors++; $display("FAIL tap_changed_hi: got %0b expected 1", changed_w); end
        tick();
        checks++; if (changed_w !== 1'b0) begin errors++; $display("FAIL tap_changed_lo: got %0b expected 0", changed_w); end
        inc_state = 1'b0;
        tick(); tick(); tick();
        checks++; if (count_w !== 4'd1) begin errors++; $display("FAIL tap_final: got %0d expected 1", count_w); end
        checks++; if (pulses_w !== 1) begin errors++; $display("FAIL tap_pulses: got %0d expected 1", pulses_w); end
    endtask

    task automatic test_hold_repeat();
        int steps[6] = '{0, 10, 14, 18, 22, 26};
        int exp_cnt;
        bit exp_ch;
        apply_reset();
        inc_down  = 1'b1;
        inc_state = 1'b1;
        tick();
        inc_down = 1'b0;
        for (int k = 1; k < 30; k++) begin
            tick();
            exp_cnt = 0;
            exp_ch  = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (steps[i] + 1 <= k) exp_cnt++;
                if (steps[i] + 1 == k) exp_ch = 1'b1;
            end
            checks++; if (count_w !== 4'(exp_cnt)) begin errors++; $display("FAIL hold_count k=%0d: got %0d expected %0d", k, count_w, exp_cnt); end
            checks++; if (changed_w !== exp_ch) begin errors++; $display("FAIL hold_changed k=%0d: got %0b expected %0b", k, changed_w, exp_ch); end
        end
        inc_state = 1'b0;
        tick(); tick();
        checks++; if (count_w !== 4'd6) begin errors++; $display("FAIL hold_final: got %0d expected 6", count_w); end
        checks++; if (pulses_w !== 6) begin errors++; $display("FAIL hold_pulses: got %0d expected 6", pulses_w); end
        checks++; if (dut_w.u_inc_rep.state_q !== ST_IDLE) begin errors++; $display("FAIL hold_idle: got %0d expected %0d", dut_w.u_inc_rep.state_q, ST_IDLE); end
    endtask

    task automatic test_wrap_sat();
        logic chw, chs;
        apply_reset();
        tap(1'b0, 1'b1, chw, chs);
        checks++; if (count_w !== 4'd15) begin errors++; $display("FAIL wrap_dec_count: got %0d expected 15", count_w); end
        checks++; if (chw !== 1'b1) begin errors++; $display("FAIL wrap_dec_changed: got %0b expected 1", chw); end
        checks++; if (count_s !== 4'd0) begin errors++; $display("FAIL sat_dec_count: got %0d expected 0", count_s); end
        checks++; if (chs !== 1'b0) begin errors++; $display("FAIL sat_dec_changed: got %0b expected 0", chs); end
        apply_reset();
        repeat (15) tap(1'b1, 1'b0, chw, chs);
        checks++; if (count_w !== 4'd15) begin errors++; $display("FAIL wrap_fill: got %0d expected 15", count_w); end
        checks++; if (count_s !== 4'd15) begin errors++; $display("FAIL sat_fill: got %0d expected 15", count_s); end
        tap(1'b1, 1'b0, chw, chs);
        checks++; if (count_w !== 4'd0) begin errors++; $display("FAIL wrap_inc_count: got %0d expected 0", count_w); end
        checks++; if (chw !== 1'b1) begin errors++; $display("FAIL wrap_inc_changed: got %0b expected 1", chw); end
        checks++; if (count_s !== 4'd15) begin errors++; $display("FAIL sat_inc_count: got %0d expected 15", count_s); end
        checks++; if (chs !== 1'b0) begin errors++; $display("FAIL sat_inc_changed: got %0b expected 0", chs); end
        checks++; if (pulses_s !== 15) begin errors++; $display("FAIL sat_pulses: got %0d expected 15", pulses_s); end
    endtask

    task automatic test_simultaneous();
        logic chw, chs;
        apply_reset();
        repeat (5) tap(1'b1, 1'b0, chw, chs);
        tap(1'b1, 1'b1, chw, chs);
        checks++; if (count_w !== 4'd5) begin errors++; $display("FAIL simul_tap_count: got %0d expected 5", count_w); end
        checks++; if (chw !== 1'b0) begin errors++; $display("FAIL simul_tap_changed: got %0b expected 0", chw); end
        pulses_w = 0;
        inc_down = 1'b1; inc_state = 1'b1;
        dec_down = 1'b1; dec_state = 1'b1;
        tick();
        inc_down = 1'b0; dec_down = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if (count_w !== 4'd5) begin errors++; $display("FAIL simul_hold k=%0d: got %0d expected 5", k, count_w); end
        end
        inc_state = 1'b0; dec_state = 1'b0;
        tick(); tick();
        checks++; if (pulses_w !== 0) begin errors++; $display("FAIL simul_pulses: got %0d expected 0", pulses_w); end
        inc_down = 1'b1; inc_state = 1'b1;
        tick();
        inc_down = 1'b0;
        dec_down = 1'b1; dec_state = 1'b1;
        tick();
        dec_down = 1'b0;
        checks++; if (count_w !== 4'd6) begin errors++; $display("FAIL stagger_inc: got %0d expected 6", count_w); end
        tick();
        checks++; if (count_w !== 4'd5) begin errors++; $display("FAIL stagger_dec: got %0d expected 5", count_w); end
        checks++; if (changed_w !== 1'b1) begin errors++; $display("FAIL stagger_changed: got %0b expected 1", changed_w); end
        inc_state = 1'b0; dec_state = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_repeat();
        apply_reset();
        inc_down = 1'b1; inc_state = 1'b1;
        tick();
        inc_down = 1'b0;
        repeat (15) tick();
        checks++; if (count_w !== 4'd3) begin errors++; $display("FAIL midrst_pre: got %0d expected 3", count_w); end
        rst = 1'b1;
        #2;
        checks++; if (count_w !== 4'd0) begin errors++; $display("FAIL midrst_async_w: got %0d expected 0", count_w); end
        checks++; if (count_s !== 4'd0) begin errors++; $display("FAIL midrst_async_s: got %0d expected 0", count_s); end
        tick();
        rst = 1'b0;
        pulses_w = 0;
        repeat (20) tick();
        checks++; if (count_w !== 4'd0) begin errors++; $display("FAIL midrst_held: got %0d expected 0", count_w); end
        checks++; if (pulses_w !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d expected 0", pulses_w); end
        inc_down = 1'b1;
        tick();
        inc_down = 1'b0;
        tick();
        checks++; if (count_w !== 4'd1) begin errors++; $display("FAIL midrst_repress: got %0d expected 1", count_w); end
        inc_state = 1'b0;
        tick(); tick();
    endtask

    task automatic test_early_release();
        apply_reset();
        inc_down = 1'b1; inc_state = 1'b1;
        tick();
        inc_down = 1'b0;
        repeat (9) tick();
        checks++; if (dut_w.u_inc_rep.timer_q !== 4'd9) begin errors++; $display("FAIL early_timer: got %0d expected 9", dut_w.u_inc_rep.timer_q); end
        inc_state = 1'b0;
        tick(); tick(); tick();
        checks++; if (count_w !== 4'd1) begin errors++; $display("FAIL early_count: got %0d expected 1", count_w); end
        checks++; if (pulses_w !== 1) begin errors++; $display("FAIL early_pulses: got %0d expected 1", pulses_w); end
        checks++; if (dut_w.u_inc_rep.state_q !== ST_IDLE) begin errors++; $display("FAIL early_idle: got %0d expected %0d", dut_w.u_inc_rep.state_q, ST_IDLE); end
    endtask

    initial begin
        rst       = 1'b1;
        inc_down  = 1'b0;
        inc_state = 1'b0;
        dec_down  = 1'b0;
        dec_state = 1'b0;
        test_reset();
        test_single_tap();
        test_hold_repeat();
        test_wrap_sat();
        test_simultaneous();
        test_reset_mid_repeat();
        test_early_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
